riscv_nn_apu_wb_buffer: RTL and testbench

- Sits directly downstream of the APU dispatcher on the response side.
- Takes APU results (data, flags, and the write address resolved by the dispatcher) and drives the shared register-file write port B.
- The LSU has priority on that port, so results that cannot be written immediately are held in a small in-order FIFO.
- Exposes backpressure to the APU interconnect, and a read-dependency flag for buffered destinations so decode stalls correctly.

---
 rtl/riscv_nn_apu_wb_buffer.sv | 148 ++++++++++++++
 tb/tb_riscv_nn_apu_wb_buffer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_nn_apu_wb_buffer.sv
// APU result write-back buffer: drives register-file port B behind the LSU, holding
// blocked results in an in-order FIFO. Define RISCV_NN_APU_WB_FWD_EN to add operand forwarding.
module riscv_nn_apu_wb_buffer #(
  parameter  int unsigned DEPTH   = 2,
  parameter  int unsigned FLAGS_W = 5,
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 apu_master_valid_i,
  input  logic [31:0]          apu_master_result_i,
  input  logic [FLAGS_W-1:0]   apu_master_flags_i,
  input  logic [5:0]           apu_waddr_i,
  output logic                 apu_master_ready_o,
  input  logic                 lsu_we_i,
  output logic                 regfile_we_o,
  output logic [5:0]           regfile_waddr_o,
  output logic [31:0]          regfile_wdata_o,
  output logic                 flags_valid_o,
  output logic [FLAGS_W-1:0]   flags_o,
  input  logic [2:0][5:0]      read_regs_i,
  input  logic [2:0]           read_regs_valid_i,
  input  logic                 is_decoding_i,
  output logic                 read_dep_o,
`ifdef RISCV_NN_APU_WB_FWD_EN
  output logic [2:0]           fwd_hit_o,
  output logic [2:0][31:0]     fwd_data_o,
`endif
  output logic [CNT_W-1:0]     count_o,
  output logic                 pending_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]        data_q  [DEPTH];
  logic [5:0]         addr_q  [DEPTH];
  logic [FLAGS_W-1:0] flags_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic empty, accept, port_free, pop, push, bypass;

  // Physical slot holding the k-th oldest entry.
  function automatic logic [PTR_W-1:0] slot_of(input logic [PTR_W-1:0] base,
                                               input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty              = (count_q == '0);
  assign apu_master_ready_o = (count_q < CNT_W'(DEPTH));
  assign accept             = apu_master_valid_i & apu_master_ready_o;
  assign port_free          = !lsu_we_i;
  assign pop                = !empty & port_free;
  // A result only skips the FIFO when nothing older is waiting for the port.
  assign bypass             = empty & accept & port_free;
  assign push               = accept & !bypass;
  assign count_o            = count_q;
  assign pending_o          = !empty;

  // rst_ni gates the port so a result offered during reset never reaches the regfile.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    regfile_we_o    = 1'b0;
    regfile_waddr_o = '0;
    regfile_wdata_o = '0;
    flags_o         = '0;
    if (rst_ni && pop) begin
      regfile_we_o    = 1'b1;
      regfile_waddr_o = addr_q[rd_ptr_q];
      regfile_wdata_o = data_q[rd_ptr_q];
      flags_o         = flags_q[rd_ptr_q];
    end else if (rst_ni && bypass) begin
      regfile_we_o    = 1'b1;
      regfile_waddr_o = apu_waddr_i;
      regfile_wdata_o = apu_master_result_i;
      flags_o         = apu_master_flags_i;
    end
  end

  assign flags_valid_o = regfile_we_o;

  // Walk entries oldest to youngest so the last match seen is the youngest one.
  logic [2:0] op_match;
`ifdef RISCV_NN_APU_WB_FWD_EN
  logic [2:0][31:0] fwd_data;
`endif
  always_comb begin
    logic [PTR_W-1:0] slot;
    op_match = '0;
`ifdef RISCV_NN_APU_WB_FWD_EN
    fwd_data = '0;
`endif
    for (int i = 0; i < 3; i++) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        slot = slot_of(rd_ptr_q, k);
        if ((k < 32'(count_q)) && read_regs_valid_i[2'(i)] &&
            (read_regs_i[2'(i)] == addr_q[slot])) begin
          op_match[2'(i)] = 1'b1;
`ifdef RISCV_NN_APU_WB_FWD_EN
          fwd_data[2'(i)] = data_q[slot];
`endif
        end
      end
    end
  end

`ifdef RISCV_NN_APU_WB_FWD_EN
  assign fwd_hit_o  = op_match;
  assign fwd_data_o = fwd_data;
  assign read_dep_o = is_decoding_i & |(op_match & ~fwd_hit_o);
`else
  assign read_dep_o = is_decoding_i & |op_match;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the payload storage is not reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_q[wr_ptr_q]  <= apu_master_result_i;
      addr_q[wr_ptr_q]  <= apu_waddr_i;
      flags_q[wr_ptr_q] <= apu_master_flags_i;
    end
  end

endmodule

// File: tb/tb_riscv_nn_apu_wb_buffer.sv
// Bench for riscv_nn_apu_wb_buffer: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based reference model.
module tb_riscv_nn_apu_wb_buffer;
  localparam int DEPTH   = 2;
  localparam int FLAGS_W = 5;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               apu_master_valid_i;
  logic [31:0]        apu_master_result_i;
  logic [FLAGS_W-1:0] apu_master_flags_i;
  logic [5:0]         apu_waddr_i;
  logic               apu_master_ready_o;
  logic               lsu_we_i;
  logic               regfile_we_o;
  logic [5:0]         regfile_waddr_o;
  logic [31:0]        regfile_wdata_o;
  logic               flags_valid_o;
  logic [FLAGS_W-1:0] flags_o;
  logic [2:0][5:0]    read_regs_i;
  logic [2:0]         read_regs_valid_i;
  logic               is_decoding_i;
  logic               read_dep_o;
`ifdef RISCV_NN_APU_WB_FWD_EN
  logic [2:0]         fwd_hit_o;
  logic [2:0][31:0]   fwd_data_o;
`endif
  logic [CNT_W-1:0]   count_o;
  logic               pending_o;

  riscv_nn_apu_wb_buffer #(.DEPTH(DEPTH), .FLAGS_W(FLAGS_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .apu_master_valid_i(apu_master_valid_i), .apu_master_result_i(apu_master_result_i),
    .apu_master_flags_i(apu_master_flags_i), .apu_waddr_i(apu_waddr_i),
    .apu_master_ready_o(apu_master_ready_o), .lsu_we_i(lsu_we_i),
    .regfile_we_o(regfile_we_o), .regfile_waddr_o(regfile_waddr_o),
    .regfile_wdata_o(regfile_wdata_o), .flags_valid_o(flags_valid_o), .flags_o(flags_o),
    .read_regs_i(read_regs_i), .read_regs_valid_i(read_regs_valid_i),
    .is_decoding_i(is_decoding_i), .read_dep_o(read_dep_o),
`ifdef RISCV_NN_APU_WB_FWD_EN
    .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o),
`endif
    .count_o(count_o), .pending_o(pending_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [5:0]         addr;
    logic [31:0]        data;
    logic [FLAGS_W-1:0] flags;
  } entry_t;

  entry_t q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Compare every output against the model at the negedge (inputs are stable here).
  task automatic settle();
    logic               e_ready, e_acc, e_we, e_dep;
    logic [5:0]         e_addr;
    logic [31:0]        e_data;
    logic [FLAGS_W-1:0] e_flags;
    logic [2:0]         hit;
    logic [2:0][31:0]   hdata;
    @(negedge clk_i);
    e_ready = (q.size() < DEPTH);
    e_acc   = apu_master_valid_i && e_ready;
    e_we = 0; e_addr = 0; e_data = 0; e_flags = 0;
    if (!lsu_we_i && q.size() > 0) begin
      e_we = 1; e_addr = q[0].addr; e_data = q[0].data; e_flags = q[0].flags;
    end else if (!lsu_we_i && e_acc) begin
      e_we = 1; e_addr = apu_waddr_i; e_data = apu_master_result_i; e_flags = apu_master_flags_i;
    end
    hit = '0; hdata = '0;
    for (int i = 0; i < 3; i++)
      foreach (q[k])
        if (read_regs_valid_i[i] && q[k].addr == read_regs_i[i]) begin
          hit[i] = 1'b1; hdata[i] = q[k].data;
        end
`ifdef RISCV_NN_APU_WB_FWD_EN
    e_dep = 1'b0;
    check("fwd_hit", 32'(fwd_hit_o), 32'(hit));
    for (int i = 0; i < 3; i++) if (hit[i]) check("fwd_data", fwd_data_o[i], hdata[i]);
`else
    e_dep = is_decoding_i && (hit != 3'b000);
`endif
    check("ready",       32'(apu_master_ready_o), 32'(e_ready));
    check("we",          32'(regfile_we_o),       32'(e_we));
    check("flags_valid", 32'(flags_valid_o),      32'(e_we));
    check("waddr",       32'(regfile_waddr_o),    32'(e_addr));
    check("wdata",       regfile_wdata_o,         e_data);
    check("flags",       32'(flags_o),            32'(e_flags));
    check("read_dep",    32'(read_dep_o),         32'(e_dep));
    check("count",       32'(count_o),            32'(q.size()));
    check("pending",     32'(pending_o),          32'(q.size() != 0));
  endtask

  // Advance the model across the clock edge, using the inputs held since settle().
  task automatic advance(output logic accepted);
    logic acc, byp;
    @(posedge clk_i);
    acc = apu_master_valid_i && (q.size() < DEPTH);
    byp = !lsu_we_i && q.size() == 0 && acc;
    if (!lsu_we_i && q.size() > 0) void'(q.pop_front());
    if (acc && !byp) q.push_back('{apu_waddr_i, apu_master_result_i, apu_master_flags_i});
    accepted = acc;
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] a, input logic [31:0] d, input logic lsu);
    apu_master_valid_i  = v;
    apu_waddr_i         = a;
    apu_master_result_i = d;
    apu_master_flags_i  = FLAGS_W'(d[4:0]);
    lsu_we_i            = lsu;
  endtask

  initial begin
    logic acc;
    rst_ni = 1'b0;
    drive(0, 0, 0, 0);
    read_regs_i = '0; read_regs_valid_i = '0; is_decoding_i = 0;
    #2;
    check("rst_count", 32'(count_o), 0);
    check("rst_ready", 32'(apu_master_ready_o), 1);
    check("rst_we",    32'(regfile_we_o), 0);
    check("rst_pend",  32'(pending_o), 0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Bypass
    drive(1, 5, 32'hDEADBEEF, 0);
    settle();
    check("byp_we", 32'(regfile_we_o), 1);
    check("byp_addr", 32'(regfile_waddr_o), 5);
    check("byp_data", regfile_wdata_o, 32'hDEADBEEF);
    check("byp_dep", 32'(read_dep_o), 0);
    advance(acc);
    drive(0, 0, 0, 0);
    settle();
    check("byp_count", 32'(count_o), 0);
    advance(acc);

    // LSU conflict
    drive(1, 3, 32'hA, 1); settle(); advance(acc);
    drive(1, 4, 32'hB, 1); settle(); check("lsu_cnt1", 32'(count_o), 1); advance(acc);
    drive(0, 0, 0, 1); settle();
    check("lsu_cnt2", 32'(count_o), 2);
    check("lsu_rdy0", 32'(apu_master_ready_o), 0);
    advance(acc);
    drive(0, 0, 0, 0); settle();
    check("lsu_wA", 32'(regfile_waddr_o), 3);
    advance(acc);
    settle();
    check("lsu_wB", 32'(regfile_waddr_o), 4);
    check("lsu_wBd", regfile_wdata_o, 32'hB);
    advance(acc);
    settle(); check("lsu_cnt0", 32'(count_o), 0); advance(acc);

    // Ordering
    drive(1, 10, 32'hA0, 1); settle(); advance(acc);
    drive(1, 11, 32'hC0, 0); settle();
    check("ord_wA", 32'(regfile_waddr_o), 10);
    advance(acc);
    drive(0, 0, 0, 0); settle();
    check("ord_cnt", 32'(count_o), 1);
    check("ord_wC", 32'(regfile_waddr_o), 11);
    advance(acc);
    settle(); advance(acc);

    // Full backpressure
    drive(1, 12, 32'h12, 1); settle(); advance(acc);
    drive(1, 13, 32'h13, 1); settle(); advance(acc);
    drive(1, 14, 32'h14, 1);
    repeat (2) begin
      settle(); check("bp_rdy0", 32'(apu_master_ready_o), 0); advance(acc);
    end
    lsu_we_i = 0;
    settle(); check("bp_w12", 32'(regfile_waddr_o), 12); check("bp_rdy", 32'(apu_master_ready_o), 0);
    advance(acc);
    settle(); check("bp_w13", 32'(regfile_waddr_o), 13); check("bp_rdy1", 32'(apu_master_ready_o), 1);
    advance(acc);
    check("bp_acc", 32'(acc), 1);
    drive(0, 0, 0, 0);
    settle(); check("bp_w14", 32'(regfile_waddr_o), 14); check("bp_d14", regfile_wdata_o, 32'h14);
    advance(acc);
    settle(); advance(acc);

    // Dependency
    drive(1, 7, 32'h77, 1); settle(); advance(acc);
    drive(0, 0, 0, 1);
    read_regs_i = '0; read_regs_i[1] = 6'd7; read_regs_valid_i = 3'b010; is_decoding_i = 1;
    settle();
`ifdef RISCV_NN_APU_WB_FWD_EN
    check("dep_hit", 32'(fwd_hit_o), 32'b010);
    check("dep_fwd", 32'(read_dep_o), 0);
`else
    check("dep_on", 32'(read_dep_o), 1);
`endif
    advance(acc);
    is_decoding_i = 0; settle(); check("dep_off", 32'(read_dep_o), 0); advance(acc);
    read_regs_valid_i = '0;

    // Reset mid-operation with two buffered entries
    drive(1, 8, 32'h88, 1); settle(); advance(acc);
    drive(0, 0, 0, 0);
    check("pre_rst_cnt", 32'(count_o), 2);
    rst_ni = 1'b0; #1;
    check("mrst_count", 32'(count_o), 0);
    check("mrst_we", 32'(regfile_we_o), 0);
    check("mrst_ready", 32'(apu_master_ready_o), 1);
    q.delete();
    @(posedge clk_i); #1 rst_ni = 1'b1;
    repeat (3) begin
      settle(); check("post_rst_we", 32'(regfile_we_o), 0); advance(acc);
    end

    // Randomized traffic; an unaccepted result is held stable until taken.
    begin
      logic held = 0;
      for (int c = 0; c < 3000; c++) begin
        if (!held) drive($urandom_range(0, 9) < 6, 6'($urandom_range(0, 7) + ($urandom_range(0, 1) ? 32 : 0)),
                         $urandom, 0);
        lsu_we_i = ($urandom_range(0, 1) == 1);
        for (int i = 0; i < 3; i++) read_regs_i[i] = 6'($urandom_range(0, 7) + ($urandom_range(0, 3) == 0 ? 32 : 0));
        read_regs_valid_i = 3'($urandom);
        is_decoding_i = ($urandom_range(0, 3) != 0);
        settle();
        advance(acc);
        held = apu_master_valid_i && !acc;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
